mb_rtu_rx: RTL

Modbus RTU response receiver for the master side of the bus. It consumes bytes from the UART receiver and delimits frames by the 3.5-character silent interval. It checks slave address, function code, byte count and CRC-16, streams register words for read responses (0x03/0x04), and reports exception responses and frame errors. It sits between the UART RX and the polling controller that drives the request transmitter.

---
 rtl/mb_rtu_rx.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mb_rtu_rx.sv
`default_nettype none
// ============================================================================
// Module   : mb_rtu_rx
// Brief    : Modbus RTU master-side response receiver with T3.5 framing,
//            CRC-16 check and register word streaming.
// Revision : 1.0
// ============================================================================
module mb_rtu_rx #(
  parameter logic [15:0] T35_CYCLES = 16'd1750,
  parameter logic [7:0]  MAX_BCNT   = 8'd250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  slave_addr,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        word_valid,
  output logic [15:0] word_data,
  output logic [6:0]  word_idx,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic [7:0]  fun_out,
  output logic [7:0]  exc_code,
  output logic [7:0]  byte_cnt
);

  localparam logic [15:0] c_crc_init = 16'hFFFF;
  localparam logic [15:0] c_crc_poly = 16'hA001;

  // The address compare is folded into IDLE, so no separate ADDR_CHK cycle.
  typedef enum logic [3:0] {
    S_GAP    = 4'd0,
    S_IDLE   = 4'd1,
    S_FUNC   = 4'd2,
    S_BCNT   = 4'd3,
    S_DATA   = 4'd4,
    S_EXC    = 4'd5,
    S_CRC_LO = 4'd6,
    S_CRC_HI = 4'd7
  } state_t;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ c_crc_poly) : (c >> 1);
    end
    return c;
  endfunction

  state_t      r_state;
  logic [15:0] r_sil;
  logic [15:0] r_crc;
  logic [7:0]  r_crc_lo;
  logic [7:0]  r_hi;
  logic [7:0]  r_rem;
  logic [7:0]  r_bcnt;
  logic [7:0]  r_fun;
  logic [7:0]  r_exc;
  logic [6:0]  r_idx;
  logic        r_ph;
  logic        r_is_exc;

  logic        w_mid;
  logic        w_tmo;
  logic [15:0] w_crc_next;

  assign w_crc_next = crc_step((r_state == S_IDLE) ? c_crc_init : r_crc, rx_data);
  assign w_mid      = (r_state != S_GAP) && (r_state != S_IDLE);
  // Terminal count: the counter becomes T35_CYCLES on this edge unless a byte wins.
  assign w_tmo      = w_mid && !rx_valid && (r_sil == T35_CYCLES - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_GAP;
      r_sil      <= 16'd0;
      r_crc      <= c_crc_init;
      r_crc_lo   <= 8'd0;
      r_hi       <= 8'd0;
      r_rem      <= 8'd0;
      r_bcnt     <= 8'd0;
      r_fun      <= 8'd0;
      r_exc      <= 8'd0;
      r_idx      <= 7'd0;
      r_ph       <= 1'b0;
      r_is_exc   <= 1'b0;
      word_valid <= 1'b0;
      word_data  <= 16'd0;
      word_idx   <= 7'd0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 3'd0;
      fun_out    <= 8'd0;
      exc_code   <= 8'd0;
      byte_cnt   <= 8'd0;
    end else begin
      word_valid <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;

      if (rx_valid) begin
        r_sil <= 16'd0;
      end else if (r_sil != T35_CYCLES) begin
        r_sil <= r_sil + 16'd1;
      end

      if (w_tmo) begin
        // Bus is already silent, so the next byte may start a frame at once.
        frame_err <= 1'b1;
        err_code  <= 3'd2;
        r_state   <= S_IDLE;
      end else begin
        case (r_state)
          S_GAP: begin
            if (!rx_valid && r_sil == T35_CYCLES) r_state <= S_IDLE;
          end
          S_IDLE: begin
            if (rx_valid) begin
              r_crc   <= w_crc_next;
              r_state <= (rx_data == slave_addr) ? S_FUNC : S_GAP;
            end
          end
          S_FUNC: begin
            if (rx_valid) begin
              r_crc <= w_crc_next;
              r_fun <= rx_data;
              case (rx_data)
                8'h03, 8'h04: begin
                  r_is_exc <= 1'b0;
                  r_state  <= S_BCNT;
                end
                8'h83, 8'h84: begin
                  r_is_exc <= 1'b1;
                  r_bcnt   <= 8'd0;
                  r_state  <= S_EXC;
                end
                default: begin
                  frame_err <= 1'b1;
                  err_code  <= 3'd3;
                  r_state   <= S_GAP;
                end
              endcase
            end
          end
          S_BCNT: begin
            if (rx_valid) begin
              r_crc <= w_crc_next;
              if (rx_data == 8'd0 || rx_data[0] || rx_data > MAX_BCNT) begin
                frame_err <= 1'b1;
                err_code  <= 3'd4;
                r_state   <= S_GAP;
              end else begin
                r_bcnt  <= rx_data;
                r_rem   <= rx_data;
                r_ph    <= 1'b0;
                r_idx   <= 7'd0;
                r_state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (rx_valid) begin
              r_crc <= w_crc_next;
              r_ph  <= ~r_ph;
              r_rem <= r_rem - 8'd1;
              if (!r_ph) begin
                r_hi <= rx_data;
              end else begin
                word_valid <= 1'b1;
                word_data  <= {r_hi, rx_data};
                word_idx   <= r_idx;
                r_idx      <= r_idx + 7'd1;
              end
              if (r_rem == 8'd1) r_state <= S_CRC_LO;
            end
          end
          S_EXC: begin
            if (rx_valid) begin
              r_crc   <= w_crc_next;
              r_exc   <= rx_data;
              r_state <= S_CRC_LO;
            end
          end
          S_CRC_LO: begin
            if (rx_valid) begin
              r_crc_lo <= rx_data;
              r_state  <= S_CRC_HI;
            end
          end
          S_CRC_HI: begin
            if (rx_valid) begin
              r_state <= S_GAP;
              fun_out <= r_fun;
              if ({rx_data, r_crc_lo} != r_crc) begin
                frame_err <= 1'b1;
                err_code  <= 3'd1;
              end else if (r_is_exc) begin
                frame_err <= 1'b1;
                err_code  <= 3'd5;
                exc_code  <= r_exc;
              end else begin
                frame_ok <= 1'b1;
                byte_cnt <= r_bcnt;
              end
            end
          end
          default: r_state <= S_GAP;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
